// File: rtl/wb_master_lsu.sv
// Wishbone load/store master: one access at a time.
// Sub-word lanes are steered onto the bus, load results are sign- or
// zero-extended, and a bus that never acknowledges is abandoned after
// TIMEOUT_CYCLES.
module wb_master_lsu #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [31:0]           i_wb_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, FINISH} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
  logic [1:0]        lo_q, lo_nx;
  logic [1:0]        size_q, size_nx;
  logic              uns_q, uns_nx;
  logic              busy_nx, done_nx, err_nx;
  logic [31:0]       rdata_nx;
  logic              cyc_nx, stb_nx, we_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [31:0]       wbdata_nx;
  logic [3:0]        sel_nx;

  // Address bits beyond the bus width are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];

  function automatic logic bad_req(input logic [1:0] lo, input logic [1:0] sz);
    case (sz)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = lo[0];
      2'b10:   bad_req = (lo != 2'b00);
      default: bad_req = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] lo, input logic [1:0] sz);
    case (sz)
      2'b00:   lane_sel = 4'b0001 << lo;
      2'b01:   lane_sel = 4'b0011 << lo;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] w, input logic [1:0] sz);
    case (sz)
      2'b00:   lane_wdata = {4{w[7:0]}};
      2'b01:   lane_wdata = {2{w[15:0]}};
      default: lane_wdata = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    load_ext = r;
  endfunction

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    cnt_inc   = cnt + CNT_W'(1);
    lo_nx     = lo_q;
    size_nx   = size_q;
    uns_nx    = uns_q;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    rdata_nx  = 32'd0;
    cyc_nx    = o_wb_cyc;
    stb_nx    = o_wb_stb;
    we_nx     = o_wb_we;
    addr_nx   = o_wb_addr;
    wbdata_nx = o_wb_data;
    sel_nx    = o_wb_sel;
    case (state)
      IDLE: begin
        if (i_req) begin
          cnt_nx = '0;
          if (bad_req(i_addr[1:0], i_size)) begin
            state_nx = FINISH;
            done_nx  = 1'b1;
            err_nx   = 1'b1;
          end else begin
            state_nx  = STROBE;
            cyc_nx    = 1'b1;
            stb_nx    = 1'b1;
            we_nx     = i_we;
            addr_nx   = {i_addr[ADDR_WIDTH-1:2], 2'b00};
            wbdata_nx = lane_wdata(i_wdata, i_size);
            sel_nx    = lane_sel(i_addr[1:0], i_size);
            lo_nx     = i_addr[1:0];
            size_nx   = i_size;
            uns_nx    = i_unsigned;
          end
        end
      end
      STROBE, WAIT_ACK: begin
        cnt_nx = cnt_inc;
        if (state == STROBE && !i_wb_stall) begin
          stb_nx = 1'b0;
          if (!i_wb_ack) state_nx = WAIT_ACK;
        end
        if (o_wb_cyc && i_wb_ack && (state == WAIT_ACK || !i_wb_stall)) begin
          state_nx = FINISH;
          cyc_nx   = 1'b0;
          stb_nx   = 1'b0;
          done_nx  = 1'b1;
          rdata_nx = o_wb_we ? 32'd0 : load_ext(i_wb_data, lo_q, size_q, uns_q);
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_nx = FINISH;
          cyc_nx   = 1'b0;
          stb_nx   = 1'b0;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Control state and bus/handshake outputs, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= 32'd0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= 32'd0;
      o_wb_sel  <= 4'd0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      o_busy    <= busy_nx;
      o_done    <= done_nx;
      o_err     <= err_nx;
      o_rdata   <= rdata_nx;
      o_wb_cyc  <= cyc_nx;
      o_wb_stb  <= stb_nx;
      o_wb_we   <= we_nx;
      o_wb_addr <= addr_nx;
      o_wb_data <= wbdata_nx;
      o_wb_sel  <= sel_nx;
    end
  end

  // Latched request attributes used to steer and extend load data.
  always_ff @(posedge i_clk) begin
    lo_q   <= lo_nx;
    size_q <= size_nx;
    uns_q  <= uns_nx;
  end

endmodule

// File: doc/wb_master_lsu.md
WB_MASTER_LSU -- requirements
Module: wb_master_lsu

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL be the Wishbone byte-address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum bus-wait cycles before abort.
REQ-003 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_req  in  1  access request, sampled only in IDLE.
REQ-006 i_we  in  1  1 = store, 0 = load.
REQ-007 i_addr  in  32  byte address.
REQ-008 i_wdata  in  32  store data, right-aligned.
REQ-009 i_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 i_unsigned  in  1  zero-extend loads when 1.
REQ-011 o_busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 o_done  out  1  one-cycle completion pulse.
REQ-013 o_err  out  1  qualifies o_done: misaligned, illegal size or timeout.
REQ-014 o_rdata  out  32  extended load result, valid with o_done.
REQ-015 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
REQ-016 o_wb_addr  out  ADDR_WIDTH  word-aligned byte address.
REQ-017 o_wb_data  out  32  write data.
REQ-018 o_wb_sel  out  4  byte-lane enables.
REQ-019 i_wb_ack, i_wb_stall  in  1 each; i_wb_data  in  32  slave response.

Function
REQ-020 The FSM SHALL have states IDLE, STROBE, WAIT_ACK and FINISH, with all outputs registered.
REQ-021 In IDLE with i_req=1, the block SHALL check alignment: half needs addr[0]=0, word needs addr[1:0]=0; size 11 is an error.
REQ-022 On an error the block SHALL go to FINISH with no bus cycle, asserting o_done and o_err the next cycle, with o_rdata=0.
REQ-023 On a legal request the block SHALL latch all request inputs and, the next cycle, assert o_wb_cyc=o_wb_stb=1 and enter STROBE.
REQ-024 o_wb_addr SHALL be {i_addr[ADDR_WIDTH-1:2],2'b00}.
REQ-025 o_wb_sel SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-026 o_wb_data SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-027 In STROBE, o_wb_stb SHALL stay high while i_wb_stall=1; when i_wb_stall=0 the strobe is accepted.
REQ-028 At acceptance, i_wb_ack=1 in the same cycle SHALL go to FINISH; otherwise drop o_wb_stb and enter WAIT_ACK with o_wb_cyc held high.
REQ-029 In WAIT_ACK, i_wb_ack=1 SHALL go to FINISH; i_wb_ack while o_wb_cyc=0 is ignored.
REQ-030 On entering FINISH, o_wb_cyc and o_wb_stb SHALL be 0, o_done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-031 Load data SHALL capture i_wb_data on the ack cycle, select the lane by addr[1:0] (half by addr[1]), then sign- or zero-extend per i_unsigned.
REQ-032 Stores SHALL report o_rdata=0.
REQ-033 A timeout counter SHALL clear on leaving IDLE and increment each cycle in STROBE or WAIT_ACK.
REQ-034 When the counter reaches TIMEOUT_CYCLES without ack, the block SHALL abort: cyc/stb low next cycle, o_done=o_err=1.
REQ-035 i_req while o_busy=1 SHALL be ignored and not queued.
REQ-036 A new request SHALL be accepted in the first IDLE cycle after FINISH, giving 1 idle cycle between bus cycles.
REQ-037 Minimum legal latency, from i_req to o_done with stall=0 and same-cycle ack, SHALL be 3 cycles.

Reset
REQ-038 i_rst_n=0 SHALL immediately force IDLE and clear all outputs and the counter, including mid-cycle with cyc dropped asynchronously.
REQ-039 After reset release, the first rising edge SHALL be able to sample i_req.

Verification
REQ-040 Word load, addr 0x10, slave acks same cycle returning 0xDEADBEEF -> sel=1111, o_rdata=0xDEADBEEF, o_done 3 cycles after i_req.
REQ-041 Signed byte load, addr 0x13, data 0x80112233 -> sel=1000, o_rdata=0xFFFFFF80; same with i_unsigned=1 -> 0x00000080.
REQ-042 Half store, addr 0x22, wdata 0x0000ABCD, stall held 3 cycles -> stb held 4 cycles, sel=1100, o_wb_data=0xABCDABCD, o_done without o_err.
REQ-043 Word load at addr 0x06 -> no cyc asserted, o_done=o_err=1, o_rdata=0.
REQ-044 Slave never acks -> abort after 15 wait cycles, o_err=1; then a new legal request completes normally.
REQ-045 Reset asserted in WAIT_ACK -> o_wb_cyc=0 immediately, no o_done, o_busy=0.
